// File: rtl/final_cos_pkg.sv
// final_cos_pkg: Q8.8 constants, Taylor coefficients, controller states and the acc add/sub helper (COS_SATURATE_EN)
package final_cos_pkg;
    localparam int FRAC = 8;
    localparam logic [15:0] ONE = 16'd256;
    localparam logic [15:0] C1 = 16'd128;
    localparam logic [15:0] C2 = 16'd21;
    localparam logic [15:0] C3 = 16'd9;
    typedef enum logic [3:0] {
        IDLE, SQUARE, TY1, TC1, TY2, TC2, TY3, TC3, SCALE
    } state_t;
    function automatic logic [15:0] acc_op(input logic signed [15:0] a, input logic signed [15:0] b, input logic sub);
`ifdef COS_SATURATE_EN
        logic signed [16:0] s;
        s = sub ? 17'(a) - 17'(b) : 17'(a) + 17'(b);
        return s > 17'sd32767 ? 16'h7FFF : s < -17'sd32768 ? 16'h8000 : s[15:0];
`else
        return sub ? a - b : a + b;
`endif
    endfunction
endpackage

// File: rtl/final_cos_fx_mul.sv
// fx_mul: combinational signed Q8.8 multiply, wraps or saturates under COS_SATURATE_EN
module fx_mul
    import final_cos_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] p
);
    logic signed [31:0] full;
    assign full = $signed(a) * $signed(b);
`ifdef COS_SATURATE_EN
    assign p = full > 32'sh007F_FFFF ? 16'h7FFF : full < -32'sh0080_0000 ? 16'h8000 : 16'(full >>> FRAC);
`else
    assign p = 16'(full >>> FRAC);
`endif
endmodule

// File: rtl/final_cos.sv
// final_cos: sequential Q8.8 w = x*cos(y) via 4-term Taylor series on one shared multiplier (COS_SATURATE_EN)
module final_cos
    import final_cos_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic        Ready,
    output logic [15:0] w
);
    state_t state, state_nx;
    logic [15:0] xr, yr, y2, term, tmp, acc, ma, mb, mp;
    logic tc, ty;
    fx_mul u_mul (.a(ma), .b(mb), .p(mp));
    assign tc = state inside {TC1, TC2, TC3};
    assign ty = state inside {TY1, TY2, TY3};
    assign Ready = state == IDLE;
    always_comb begin
        ma = state == SQUARE ? yr : state == SCALE ? xr : tc ? tmp : term;
        mb = state == SQUARE ? yr : state == SCALE ? acc :
             state == TC1 ? C1 : state == TC2 ? C2 : state == TC3 ? C3 : y2;
        state_nx = state == IDLE ? (start ? SQUARE : IDLE) :
                   state == SCALE ? IDLE : state_t'(state + 1'b1);
    end
    // odd Taylor terms subtract, the even one (TC2) adds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            xr <= '0;
            yr <= '0;
            y2 <= '0;
            term <= '0;
            tmp <= '0;
            acc <= '0;
            w <= '0;
        end else begin
            state <= state_nx;
            if (Ready && start) begin
                xr <= x;
                yr <= y;
                term <= ONE;
                acc <= ONE;
            end
            if (state == SQUARE) y2 <= mp;
            if (ty) tmp <= mp;
            if (tc) begin
                term <= mp;
                acc <= acc_op(acc, mp, state != TC2);
            end
            if (state == SCALE) w <= mp;
        end
    end
endmodule

// File: tb/tb_final_cos.sv
// tb_final_cos: directed bench for final_cos against a latency/arithmetic model of x*cos(y)
module tb_final_cos;
    logic clk = 0, rst = 0, start = 0;
    logic [15:0] x = 0, y = 0;
    logic Ready;
    logic [15:0] w;
    int checks = 0, errors = 0;
    int busy = 0;
    logic [15:0] exp_w = 0, pend = 0;

    final_cos dut (.clk(clk), .rst(rst), .start(start), .x(x), .y(y), .Ready(Ready), .w(w));

    always #5 clk = ~clk;

    function automatic logic [15:0] qm(input logic signed [15:0] a, input logic signed [15:0] b);
        logic signed [31:0] p;
        p = a * b;
        p = p >>> 8;
        return p[15:0];
    endfunction

    function automatic logic [15:0] cos_model(input logic [15:0] xi, input logic [15:0] yi);
        logic signed [15:0] y2, term, acc;
        y2 = qm(yi, yi);
        term = 16'sd256;
        acc = 16'sd256;
        for (int k = 1; k <= 3; k++) begin
            term = qm(qm(term, y2), k == 1 ? 16'sd128 : k == 2 ? 16'sd21 : 16'sd9);
            acc = k[0] ? acc - term : acc + term;
        end
        return qm(xi, acc);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // model: a run accepted when idle yields its result 8 edges later
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 0;
            exp_w <= 0;
        end else if (busy == 0) begin
            if (start) begin
                busy <= 8;
                pend <= cos_model(x, y);
            end
        end else begin
            busy <= busy - 1;
            if (busy == 1) exp_w <= pend;
        end
    end

    always @(negedge clk) begin
        chk("ready", {15'd0, Ready}, {15'd0, busy == 0});
        chk("w", w, exp_w);
    end

    task automatic run(input logic [15:0] xi, input logic [15:0] yi, input bit tog);
        int cyc = 0;
        x = xi;
        y = yi;
        start = 1;
        do begin
            @(negedge clk);
            cyc++;
            start = tog & cyc[0];
            x = 16'hDEAD;
            y = 16'h1234;
        end while (!Ready && cyc < 20);
        start = 0;
        chk("latency", 16'(cyc - 1), 16'd8);
    endtask

    initial begin
        int hits, first, last;
        chk("model_f6", cos_model(16'h010B, 16'h0066), 16'h00F6);
        chk("model_114", cos_model(16'h0200, 16'h0100), 16'h0114);
        #1 rst = 1;
        #1;
        chk("rst_ready", {15'd0, Ready}, 16'd1);
        chk("rst_w", w, 16'h0000);
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        chk("idle_ready", {15'd0, Ready}, 16'd1);
        run(16'h010B, 16'h0066, 0);
        chk("w_f6", w, 16'h00F6);
        run(16'h010B, 16'h000A, 0);
        chk("w_10b", w, 16'h010B);
        run(16'h0100, 16'h0000, 1);
        chk("w_100", w, 16'h0100);
        x = 16'h010B;
        y = 16'h0066;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("abort_ready", {15'd0, Ready}, 16'd1);
        chk("abort_w", w, 16'h0000);
        @(negedge clk);
        rst = 0;
        run(16'h010B, 16'h0066, 0);
        chk("w_f6_again", w, 16'h00F6);
        run(16'h0200, 16'h0100, 0);
        chk("w_114", w, 16'h0114);
        run(16'hFF00, 16'hFF00, 0);
        chk("w_ff76", w, 16'hFF76);
        x = 16'h0200;
        y = 16'h0100;
        start = 1;
        hits = 0;
        first = 0;
        last = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (Ready) begin
                if (hits == 0) first = i;
                else chk("period", 16'(i - last), 16'd9);
                last = i;
                hits++;
            end
        end
        chk("cont_hits", 16'(hits), 16'd3);
        chk("cont_first", 16'(first), 16'd9);
        start = 0;
        for (int i = 0; i < 20 && !Ready; i++) @(negedge clk);
        chk("cont_done", {15'd0, Ready}, 16'd1);
        chk("cont_w", w, 16'h0114);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
